// File: rtl/handshake_slave_fifo_if.sv
// Valid/ready bundle for handshake_slave_fifo: upstream beat channel plus downstream FIFO output channel.
interface handshake_slave_fifo_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output valid, data_in, out_ready,
    input  ready, out_valid, out_data
  );

  modport slave (
    input  valid, data_in, out_ready,
    output ready, out_valid, out_data
  );
endinterface

// File: rtl/handshake_slave_fifo.sv
// Receive-side valid/ready stage buffering accepted beats in a first-word-fall-through FIFO.
// Define HS_SLAVE_STATS_EN to add the 16-bit accepted-beat counter port beat_cnt.
module handshake_slave_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  handshake_slave_fifo_if.slave    bus,
  output logic [$clog2(DEPTH):0]   count
`ifdef HS_SLAVE_STATS_EN
  ,
  output logic [15:0]              beat_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_e;

  occ_e              state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop;

  // Occupancy state mirrors count so ready/out_valid come straight from flops.
  assign push = bus.valid && (state_q != FULL);
  assign pop  = bus.out_ready && (state_q != EMPTY);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (count_d == '0)               state_d = EMPTY;
    else if (count_d == CW'(DEPTH))  state_d = FULL;
    else                             state_d = PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Storage is never cleared; reset only discards it through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.ready     = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign count         = count_q;

`ifdef HS_SLAVE_STATS_EN
  logic [15:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)       beat_cnt_q <= '0;
    else if (push) beat_cnt_q <= beat_cnt_q + 16'd1;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_slave_fifo.sv
// Directed bench for handshake_slave_fifo with a queue scoreboard and a reference occupancy model.
module tb_handshake_slave_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] count;
`ifdef HS_SLAVE_STATS_EN
  logic [15:0]   beat_cnt;
  logic [15:0]   beats_m;
`endif

  handshake_slave_fifo_if #(.DATA_W(DATA_W)) bus ();

  handshake_slave_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .count (count)
`ifdef HS_SLAVE_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned         vectors = 0;
  int unsigned         errors  = 0;
  logic [DATA_W-1:0]   sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of stimulus: checks current outputs against the model,
  // then advances the model by the handshakes that edge will perform.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ordy,
                      input bit full_check);
    int unsigned cnt_m;
    logic        push_m, pop_m;
    cnt_m = sb_q.size();
    bus.valid     = v;
    bus.data_in   = d;
    bus.out_ready = ordy;
    if (full_check) begin
      chk("ready", 64'(bus.ready), 64'(cnt_m != DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(cnt_m != 0));
      chk("count", 64'(count), 64'(cnt_m));
    end
    push_m = v && (cnt_m != DEPTH);
    pop_m  = ordy && (cnt_m != 0);
    if (pop_m) chk("out_data", 64'(bus.out_data), 64'(sb_q.pop_front()));
    if (push_m) begin
      sb_q.push_back(d);
`ifdef HS_SLAVE_STATS_EN
      beats_m = beats_m + 16'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned n, input logic v);
    rst           = 1'b1;
    bus.valid     = v;
    bus.data_in   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
`ifdef HS_SLAVE_STATS_EN
    beats_m = '0;
`endif
  endtask

  initial begin
    bus.valid     = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle
    do_reset(2, 1'b0);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
`ifdef HS_SLAVE_STATS_EN
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    step(1'b0, 32'h1234_5678, 1'b1, 1'b1);  // out_ready while empty
    step(1'b0, 32'h8765_4321, 1'b0, 1'b1);  // data toggling with valid low

    // Single beat
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
    chk("single_visible", 64'(bus.out_data), 64'h0000_0000_A5A5_0001);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Fill to full, hold a 5th beat, then drain
    for (int unsigned i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(bus.ready), 64'd0);
    step(1'b1, 32'h5, 1'b0, 1'b1);
    step(1'b1, 32'h5, 1'b0, 1'b1);
    step(1'b1, 32'h5, 1'b1, 1'b1);  // pop while full; 5th beat accepted next cycle
    step(1'b1, 32'h5, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Streaming with wrap
    for (int unsigned i = 0; i < 20; i++) step(1'b1, 32'hC000_0000 + DATA_W'(i), 1'b1, 1'b1);
    chk("stream_count", 64'(count), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Reset mid-operation with a beat offered during the reset cycle
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'hB000_0000 + DATA_W'(i), 1'b0, 1'b1);
    do_reset(1, 1'b1);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    step(1'b1, 32'hE000_0001, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Randomised mixed traffic
    for (int unsigned i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0), 1'b1);
    for (int unsigned i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

`ifdef HS_SLAVE_STATS_EN
    do_reset(1, 1'b0);
    for (int unsigned i = 0; i < 65537; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("beat_cnt_wrap", 64'(beat_cnt), 64'd1);
    chk("beat_cnt_model", 64'(beat_cnt), 64'(beats_m));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/handshake_slave_fifo.md
# handshake_slave_fifo

Receive-side stage of the AXI4-style valid/ready channel. It consumes the `valid`/`data` beats driven by the handshake master, controls the `ready` back-pressure, and buffers accepted words in a small first-word-fall-through FIFO. It then re-presents the words on an output valid/ready port to the downstream consumer, so bursts from the master are absorbed without stalling.

## Interface
- `DATA_W`, 32: data width in bits.
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥ 2.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `valid`  input  1  upstream beat valid.
- `ready`  output  1  upstream ready. High when the FIFO is not full.
- `data_in`  input  DATA_W  upstream data, sampled on a handshake.
- `out_valid`  output  1  FIFO non-empty; `out_data` holds the head entry.
- `out_ready`  input  1  downstream accepts the head entry.
- `out_data`  output  DATA_W  head entry of the FIFO.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `beat_cnt`  output  16  accepted-beat counter. Present only when `HS_SLAVE_STATS_EN` is defined.

## Operation
- Push: occurs when `valid && ready` at a rising edge. `data_in` is written to `mem[wr_ptr]` and `wr_ptr` increments.
- Pop: occurs when `out_valid && out_ready` at a rising edge. `rd_ptr` increments.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from DEPTH-1 to 0.
- `count` update rules:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Output port derivation:
  - `ready = (count != DEPTH)`.
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]`.
  - All three are decoded from registered state only. There is no combinational path from `valid` or `out_ready` to any output.
- Occupancy states: EMPTY (count = 0), PARTIAL, FULL (count = DEPTH), moving only by the count rules above.
- Boundary conditions:
  - Full, `valid` high: `ready` is 0 and nothing is written. The master holds its beat. If a pop occurs the same cycle, `ready` returns to 1 on the next cycle.
  - Full, with push and pop in the same cycle: cannot happen, because `ready` is 0 while full.
  - Empty, with push and pop in the same cycle: cannot happen, because `out_valid` is 0 while empty. The pushed word becomes visible the next cycle.
  - `out_ready` high while empty: ignored; pointers do not move.
  - `valid` low with `data_in` changing: ignored.
- Reset behaviour (`rst` high at a rising edge, including mid-burst):
  - `wr_ptr`, `rd_ptr` and `count` clear to 0.
  - Buffered data is discarded.
  - `mem` contents are not cleared.
  - A handshake in the reset cycle is not taken.

## Timing
- Reset values of outputs:
  - `ready` = 1.
  - `out_valid` = 0.
  - `count` = 0.
  - `beat_cnt` = 0.
  - `out_data` = don't-care (reads uninitialised memory).
- Latency: a push at edge N makes the word visible as `out_valid`/`out_data` from edge N onward, i.e. one cycle after it is presented on `data_in`.
- Throughput:
  - One push and one pop per cycle sustained while 0 < count < DEPTH.
  - A continuously valid master with a continuously ready consumer runs at full rate, with count settling at 1.
- Back-pressure: `ready` deasserts the cycle after the push that fills the FIFO.

## Configuration
- `HS_SLAVE_STATS_EN` defined:
  - Port `beat_cnt` exists.
  - 16-bit register that increments on every push.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared by `rst`.
- `HS_SLAVE_STATS_EN` undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: `rst` high for 2 cycles, then low → `ready`=1, `out_valid`=0, `count`=0.
- Single beat: push 0xA5A5_0001 with `out_ready`=0 → next cycle `out_valid`=1, `out_data`=0xA5A5_0001, `count`=1. Then pulse `out_ready` for one cycle → `count`=0.
- Fill to full: DEPTH=4, push 0x1..0x4 back-to-back with `out_ready`=0 → `count`=4, `ready`=0. Drive a 5th beat 0x5 with `valid` held → not accepted. Drain → output order 0x1, 0x2, 0x3, 0x4, then 0x5 is accepted once `ready`=1.
- Streaming with wrap: 20 sequential words with `valid` and `out_ready` both held high → all 20 appear in order, no gaps after the first, `count` stays at 1, pointers wrap 5 times.
- Reset mid-operation: 3 words buffered, assert `rst` for 1 cycle → `count`=0, `out_valid`=0, and the next push is read back as the first word out.
- Stats (`HS_SLAVE_STATS_EN`): preload by pushing 65537 beats → `beat_cnt`=1 (wrap verified). With the macro undefined the build has no `beat_cnt` port.
